// File: rtl/serial_divider_if.sv
// Operand/result bus of the serial divider.
//   Run     : level start request
//   LoadB   : load dividend register B from Din (IDLE only)
//   LoadS   : load divisor register S from Din (IDLE only)
//   Din     : 8-bit operand bus
//   Aval    : remainder (A[7:0]) when Done
//   Bval    : quotient (B) when Done
//   Done    : high while the divider sits in HALT
//   DivZero : divide-by-zero flag (constant 0 unless DIV_ZERO_CHECK_EN)
// The master drives requests/operands; the slave (divider) drives results.
interface serial_divider_if;
    logic       Run;
    logic       LoadB;
    logic       LoadS;
    logic [7:0] Din;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Done;
    logic       DivZero;

    modport master (
        output Run, LoadB, LoadS, Din,
        input  Aval, Bval, Done, DivZero
    );

    modport slave (
        input  Run, LoadB, LoadS, Din,
        output Aval, Bval, Done, DivZero
    );
endinterface

// File: rtl/serial_divider.sv
// Unsigned 8-bit restoring divider: one Run accept produces quotient in B and
// remainder in A after 8 SHIFT/TRIAL pairs (16 clocks), then waits in HALT until
// Run is released.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-high reset; clears all registers, state IDLE
//   bus   : serial_divider_if.slave (Run, LoadB, LoadS, Din, Aval, Bval, Done,
//           DivZero)
// Optional feature, macro DIV_ZERO_CHECK_EN: a Run with S==0 jumps straight to
// HALT with quotient FF, remainder = dividend and a registered DivZero flag.
// Without the macro DivZero is tied 0 and S==0 runs the normal algorithm, which
// yields the same quotient/remainder.
module serial_divider (
    input  logic             Clk,
    input  logic             Reset,
    serial_divider_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StTrial, StHalt} state_e;

    state_e      state_q, state_d;
    logic [8:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  s_q, s_d;
    logic [3:0]  n_q, n_d;
    logic [8:0]  diff;
    logic        borrow;

`ifdef DIV_ZERO_CHECK_EN
    logic        dz_q, dz_d;
`endif

    // Trial subtraction; A < S signals a borrow, so the trial fails.
    assign diff   = a_q - {1'b0, s_q};
    assign borrow = (a_q < {1'b0, s_q});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        n_d     = n_q;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Run wins over loads in the same cycle.
                if (bus.Run) begin
`ifdef DIV_ZERO_CHECK_EN
                    if (s_q == 8'd0) begin
                        a_d     = {1'b0, b_q};
                        b_d     = 8'hFF;
                        dz_d    = 1'b1;
                        state_d = StHalt;
                    end else begin
                        a_d     = 9'd0;
                        n_d     = 4'd0;
                        dz_d    = 1'b0;
                        state_d = StShift;
                    end
`else
                    a_d     = 9'd0;
                    n_d     = 4'd0;
                    state_d = StShift;
`endif
                end else begin
                    if (bus.LoadB) begin
                        b_d = bus.Din;
                        a_d = 9'd0;
`ifdef DIV_ZERO_CHECK_EN
                        dz_d = 1'b0;
`endif
                    end
                    if (bus.LoadS) begin
                        s_d = bus.Din;
`ifdef DIV_ZERO_CHECK_EN
                        dz_d = 1'b0;
`endif
                    end
                end
            end
            StShift: begin
                // {A,B} <<= 1; A[8] is always 0 here because A < S after each trial.
                a_d     = {a_q[7:0], b_q[7]};
                b_d     = {b_q[6:0], 1'b0};
                state_d = StTrial;
            end
            StTrial: begin
                if (!borrow) begin
                    a_d    = diff;
                    b_d[0] = 1'b1;
                end
                n_d     = n_q + 4'd1;
                state_d = (n_q == 4'd7) ? StHalt : StShift;
            end
            StHalt: begin
                if (!bus.Run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            a_q     <= 9'd0;
            b_q     <= 8'd0;
            s_q     <= 8'd0;
            n_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            n_q     <= n_d;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end
    assign bus.DivZero = dz_q;
`else
    assign bus.DivZero = 1'b0;
`endif

    assign bus.Aval = a_q[7:0];
    assign bus.Bval = b_q;
    assign bus.Done = (state_q == StHalt);

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider.
module tb_serial_divider;

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;
    int   lat;

    serial_divider_if bus ();

    serial_divider dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

`ifdef DIV_ZERO_CHECK_EN
    localparam int   ZeroLat  = 1;
    localparam logic ZeroFlag = 1'b1;
`else
    localparam int   ZeroLat  = 17;
    localparam logic ZeroFlag = 1'b0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b, input logic [7:0] s);
        bus.LoadS = 1'b1; bus.Din = s; tick(); bus.LoadS = 1'b0;
        bus.LoadB = 1'b1; bus.Din = b; tick(); bus.LoadB = 1'b0;
    endtask

    // Counts edges from raising Run until Done; first edge (E0) counts as 1.
    task automatic wait_done(inout int l);
        while (!bus.Done && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic run_check(input string tag, input int q, input int r,
                             input int exp_lat, input logic dz);
        bus.Run = 1'b1;
        lat = 0;
        wait_done(lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " Q"}, bus.Bval, q);
        check({tag, " R"}, bus.Aval, r);
        check({tag, " DivZero"}, bus.DivZero, dz);
        bus.Run = 1'b0;
        tick();
        check({tag, " Done fall"}, bus.Done, 0);
    endtask

    initial begin
        logic [7:0] cb [5];
        logic [7:0] cs [5];
        logic [7:0] cq [5];
        logic [7:0] cr [5];
        logic [7:0] q_hold;
        cb = '{8'd255, 8'd5, 8'd200, 8'd255, 8'd0};
        cs = '{8'd1,   8'd9, 8'd200, 8'd255, 8'd13};
        cq = '{8'd255, 8'd0, 8'd1,   8'd1,   8'd0};
        cr = '{8'd0,   8'd5, 8'd0,   8'd0,   8'd0};
        n_tests = 0;
        n_fail  = 0;
        bus.Run = 1'b0; bus.LoadB = 1'b0; bus.LoadS = 1'b0; bus.Din = 8'd0;
        Reset = 1'b1;
        #12;
        check("reset Aval", bus.Aval, 0);
        check("reset Bval", bus.Bval, 0);
        check("reset Done", bus.Done, 0);
        check("reset DivZero", bus.DivZero, 0);
        Reset = 1'b0;
        tick();

        // 100 / 7 = 14 r 2
        load(8'd100, 8'd7);
        run_check("100/7", 14, 2, 17, 1'b0);

        // Chained: 14 / 7 = 2 r 0
        run_check("chain 14/7", 2, 0, 17, 1'b0);

        for (int i = 0; i < 5; i++) begin
            load(cb[i], cs[i]);
            run_check($sformatf("case %0d/%0d", cb[i], cs[i]), cq[i], cr[i], 17, 1'b0);
        end

        // Divide by zero
        load(8'd37, 8'd0);
        run_check("37/0", 255, 37, ZeroLat, ZeroFlag);
        load(8'd5, 8'd0);
        check("LoadB clears DivZero", bus.DivZero, 0);

        // Run held through HALT: Done stays, result unchanged
        load(8'd100, 8'd7);
        bus.Run = 1'b1;
        lat = 0;
        wait_done(lat);
        check("hold latency", lat, 17);
        q_hold = bus.Bval;
        repeat (10) tick();
        check("hold Done", bus.Done, 1);
        check("hold Q", bus.Bval, 14);
        check("hold Q stable", bus.Bval, q_hold);
        check("hold R", bus.Aval, 2);
        bus.Run = 1'b0;
        tick();
        check("hold Done fall", bus.Done, 0);

        // Simultaneous LoadB and Run: old B (50) used
        load(8'd50, 8'd5);
        bus.LoadB = 1'b1; bus.Din = 8'd99;
        bus.Run = 1'b1;
        tick();
        bus.LoadB = 1'b0;
        lat = 1;
        wait_done(lat);
        check("simul latency", lat, 17);
        check("simul Q", bus.Bval, 10);
        check("simul R", bus.Aval, 0);
        bus.Run = 1'b0;
        tick();

        // LoadB mid-operation ignored
        load(8'd100, 8'd7);
        bus.Run = 1'b1;
        repeat (5) tick();
        bus.LoadB = 1'b1; bus.Din = 8'd3;
        tick();
        bus.LoadB = 1'b0;
        lat = 6;
        wait_done(lat);
        check("midload latency", lat, 17);
        check("midload Q", bus.Bval, 14);
        check("midload R", bus.Aval, 2);
        bus.Run = 1'b0;
        tick();

        // Asynchronous reset mid-iteration (after E7)
        load(8'd100, 8'd7);
        bus.Run = 1'b1;
        repeat (8) tick();
        #2;
        Reset = 1'b1;
        bus.Run = 1'b0;
        #1;
        check("async Aval", bus.Aval, 0);
        check("async Bval", bus.Bval, 0);
        check("async Done", bus.Done, 0);
        check("async DivZero", bus.DivZero, 0);
        tick();
        Reset = 1'b0;
        tick();
        // S cleared by reset: 0 / 0
        run_check("0/0", 255, 0, ZeroLat, ZeroFlag);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
